// File: rtl/sha256_round_sequencer.sv
// sha256_round_sequencer: control FSM for one SHA-256 compression engine.
// Takes one 512-bit block over a valid/ready handshake.
// For that block it runs the state load, ROUNDS rounds and the final hash add,
// then presents the digest over a valid/ready handshake.
// No data passes through this block; it only drives the K ROM address and
// the datapath strobes.
// Optional build macro: SHA256_SEQ_STALL_EN adds a 'stall' input. The stall
// input freezes LOAD, ROUND and FINAL in place and suppresses their strobes.
module sha256_round_sequencer #(
   parameter int ROUNDS  = 64,
   parameter int ROUND_W = 6,
   parameter int SCHED_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic               in_first,
   output logic               in_ready,
   output logic [ROUND_W-1:0] k_addr,
   output logic               load_iv,
   output logic               load_state,
   output logic               round_en,
   output logic               w_sel,
   output logic               w_shift,
   output logic               final_add,
   output logic               out_valid,
   input  logic               out_ready,
`ifdef SHA256_SEQ_STALL_EN
   input  logic               stall,
`endif
   output logic               busy
);

   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ROUND = 3'd2,
      S_FINAL = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_reg, state_next;
   logic [ROUND_W-1:0] round_reg, round_next;
   logic               first_reg, first_next;
   logic               hold;

   // The default build behaves as if stall were tied low.
`ifdef SHA256_SEQ_STALL_EN
   assign hold = stall;
`else
   assign hold = 1'b0;
`endif

   // State, round counter and latched first-block flag; reset wins over everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         round_reg <= '0;
         first_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         round_reg <= round_next;
         first_reg <= first_next;
      end
   end

   // Next-state and round-counter update.
   always_comb begin
      state_next = state_reg;
      round_next = round_reg;
      first_next = first_reg;
      case (state_reg)
         S_IDLE: begin
            if (in_valid) begin
               state_next = S_LOAD;
               first_next = in_first;
            end
         end
         S_LOAD: begin
            if (!hold) begin
               state_next = S_ROUND;
               round_next = '0;
            end
         end
         S_ROUND: begin
            if (!hold) begin
               if (round_reg == LAST_ROUND) begin
                  // The last round leaves the counter at zero, so the counter never wraps.
                  state_next = S_FINAL;
                  round_next = '0;
               end else begin
                  round_next = round_reg + 1'b1;
               end
            end
         end
         S_FINAL: begin
            if (!hold) state_next = S_DONE;
         end
         S_DONE: begin
            // A new block cannot be taken in this cycle; IDLE takes it on the next one.
            if (out_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Moore output decode from the registered state and round; stall only masks strobes.
   always_comb begin
      in_ready   = 1'b0;
      k_addr     = '0;
      load_iv    = 1'b0;
      load_state = 1'b0;
      round_en   = 1'b0;
      w_sel      = 1'b0;
      w_shift    = 1'b0;
      final_add  = 1'b0;
      out_valid  = 1'b0;
      busy       = (state_reg != S_IDLE);
      case (state_reg)
         S_IDLE:  in_ready = 1'b1;
         S_LOAD: begin
            load_iv    = first_reg & ~hold;
            load_state = ~first_reg & ~hold;
         end
         S_ROUND: begin
            k_addr   = round_reg;
            round_en = ~hold;
            w_shift  = ~hold;
            w_sel    = (int'(round_reg) >= SCHED_W);
         end
         S_FINAL: final_add = ~hold;
         S_DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// tb_sha256_round_sequencer: stimulus from a vector table plus hand-written
// sequences. The sequences cover reset mid-round, a held-off consumer and
// back-to-back blocks.
// Expected per-block results are queued when a block is driven. A negedge
// monitor measures each block and pops and compares the results at the
// digest handshake.
module tb_sha256_round_sequencer;

   localparam int ROUNDS  = 64;
   localparam int ROUND_W = 6;
   localparam int SCHED_W = 16;
`ifdef SHA256_SEQ_STALL_EN
   localparam int STALL_CYC = 5;
`else
   localparam int STALL_CYC = 0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_first = 1'b0;
   logic               out_ready = 1'b0;
   logic               stall = 1'b0;
   logic               in_ready, load_iv, load_state, round_en, w_sel, w_shift;
   logic               final_add, out_valid, busy;
   logic [ROUND_W-1:0] k_addr;

   sha256_round_sequencer #(.ROUNDS(ROUNDS), .ROUND_W(ROUND_W), .SCHED_W(SCHED_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
      .in_ready(in_ready), .k_addr(k_addr), .load_iv(load_iv), .load_state(load_state),
      .round_en(round_en), .w_sel(w_sel), .w_shift(w_shift), .final_add(final_add),
      .out_valid(out_valid), .out_ready(out_ready),
`ifdef SHA256_SEQ_STALL_EN
      .stall(stall),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic exp_liv;
      logic exp_lst;
      int   exp_valid_c;
   } exp_t;

   typedef struct {
      logic first;
      int   ready_delay;
      int   stall_len;
      logic exp_liv;
      logic exp_lst;
      int   exp_valid_c;
   } vec_t;

   exp_t sb[$];
   int   acc_q[$];
   int   total = 0;
   int   passed = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor state for the block currently in flight.
   bit   active = 1'b0;
   int   cyc = 0, acc_cyc = 0, hs_cyc = 0, pops = 0;
   int   n_liv, n_lst, load_c, n_rounds, first_round_c, n_fin, fin_c, valid_c;
   bit   valid_drop;

   // Measure each block cycle by cycle; compare against the queued expectation at the handshake.
   always @(negedge clk) begin
      int   c;
      int   exp_k;
      exp_t e;
      cyc++;
      if (!rst_n) begin
         active = 1'b0;
         sb.delete();
      end else if (active) begin
         c = cyc - acc_cyc;
         if (load_iv) begin n_liv++; load_c = c; end
         if (load_state) begin n_lst++; load_c = c; end
         chk("w_shift_eq_round_en", int'(w_shift), int'(round_en));
         chk("in_ready_busy", int'(in_ready), 0);
         chk("busy", int'(busy), 1);
         if (round_en) begin
            chk("k_addr", int'(k_addr), n_rounds);
            chk("w_sel", int'(w_sel), (n_rounds >= SCHED_W) ? 1 : 0);
            if (n_rounds == 0) first_round_c = c;
            n_rounds++;
         end else begin
            exp_k = (stall && n_rounds > 0 && n_rounds < ROUNDS) ? n_rounds : 0;
            chk("k_addr_no_round", int'(k_addr), exp_k);
         end
         if (final_add) begin n_fin++; fin_c = c; end
         if (out_valid && valid_c < 0) valid_c = c;
         if (valid_c >= 0 && !out_valid) valid_drop = 1'b1;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("scoreboard_empty_at_take", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("load_iv_count", n_liv, int'(e.exp_liv));
               chk("load_state_count", n_lst, int'(e.exp_lst));
               chk("load_cycle", load_c, 1);
               chk("round_count", n_rounds, ROUNDS);
               chk("first_round_cycle", first_round_c, 2);
               chk("final_count", n_fin, 1);
               chk("final_cycle", fin_c, e.exp_valid_c - 1);
               chk("valid_cycle", valid_c, e.exp_valid_c);
               chk("valid_held", int'(valid_drop), 0);
               $display("block %0d: accept@%0d load@%0d rounds=%0d final@%0d valid@%0d", pops, acc_cyc, load_c, n_rounds, fin_c, valid_c);
            end
            active = 1'b0;
            hs_cyc = cyc;
            pops++;
         end
      end else begin
         chk("idle_in_ready", int'(in_ready), 1);
         chk("idle_busy", int'(busy), 0);
         chk("idle_strobes", int'({load_iv, load_state, round_en, w_shift, final_add, out_valid}), 0);
         chk("idle_k_addr", int'(k_addr), 0);
         if (in_valid && in_ready) begin
            if (sb.size() == 0) chk("unexpected_accept", 1, 0);
            active = 1'b1;
            acc_cyc = cyc;
            acc_q.push_back(cyc);
            n_liv = 0; n_lst = 0; load_c = -1; n_rounds = 0; first_round_c = -1;
            n_fin = 0; fin_c = -1; valid_c = -1; valid_drop = 1'b0;
         end
      end
   end

   task automatic wait_pops(input int target);
      for (int i = 0; i < 400; i++) begin
         if (pops >= target) return;
         tick();
      end
      chk("timeout_wait_pops", pops, target);
   endtask

   task automatic wait_out_valid();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid) return;
      end
      chk("timeout_out_valid", 0, 1);
   endtask

   task automatic wait_in_ready();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) return;
      end
      chk("timeout_in_ready", 0, 1);
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      int   target;
      bit   found;
      e.exp_liv = v.exp_liv; e.exp_lst = v.exp_lst; e.exp_valid_c = v.exp_valid_c;
      sb.push_back(e);
      target = pops + 1;
      tick();
      in_valid = 1'b1; in_first = v.first; out_ready = 1'b0;
      wait_in_ready();
      tick();
      // in_first is sampled only at accept; flipping it now must not matter.
      in_valid = 1'b0; in_first = ~v.first;
      if (v.stall_len > 0) begin
         found = 1'b0;
         for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (round_en && int'(k_addr) == 29) found = 1'b1;
         end
         if (!found) chk("timeout_round_29", 0, 1);
         tick();
         stall = 1'b1;
         repeat (v.stall_len) tick();
         stall = 1'b0;
      end
      wait_out_valid();
      tick();
      repeat (v.ready_delay) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      wait_pops(target);
   endtask

   vec_t vecs[5];

   initial begin
      int   n0;
      int   target;
      exp_t e;

      vecs[0] = '{first: 1'b1, ready_delay: 0, stall_len: 0,         exp_liv: 1'b1, exp_lst: 1'b0, exp_valid_c: 67};
      vecs[1] = '{first: 1'b0, ready_delay: 3, stall_len: 0,         exp_liv: 1'b0, exp_lst: 1'b1, exp_valid_c: 67};
      vecs[2] = '{first: 1'b0, ready_delay: 0, stall_len: 0,         exp_liv: 1'b0, exp_lst: 1'b1, exp_valid_c: 67};
      vecs[3] = '{first: 1'b1, ready_delay: 1, stall_len: 0,         exp_liv: 1'b1, exp_lst: 1'b0, exp_valid_c: 67};
      vecs[4] = '{first: 1'b1, ready_delay: 2, stall_len: STALL_CYC, exp_liv: 1'b1, exp_lst: 1'b0, exp_valid_c: 67 + STALL_CYC};

      // Power-on reset, then the reset state.
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_outputs", int'({load_iv, load_state, round_en, w_sel, w_shift, final_add, out_valid, busy}), 0);

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Reset held for 3 cycles mid-ROUND aborts the block.
      e = '{exp_liv: 1'b1, exp_lst: 1'b0, exp_valid_c: 67};
      sb.push_back(e);
      tick();
      in_valid = 1'b1; in_first = 1'b1;
      wait_in_ready();
      tick();
      in_valid = 1'b0;
      repeat (30) tick();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_in_ready", int'(in_ready), 1);
      chk("abort_busy", int'(busy), 0);
      chk("abort_outputs", int'({load_iv, load_state, round_en, w_sel, w_shift, final_add, out_valid, k_addr}), 0);

      // Consumer holds off for 10 cycles with a second block already waiting.
      e = '{exp_liv: 1'b1, exp_lst: 1'b0, exp_valid_c: 67};
      sb.push_back(e);
      e = '{exp_liv: 1'b0, exp_lst: 1'b1, exp_valid_c: 67};
      sb.push_back(e);
      target = pops + 2;
      tick();
      in_valid = 1'b1; in_first = 1'b1; out_ready = 1'b0;
      wait_in_ready();
      tick();
      in_first = 1'b0;
      n0 = acc_q.size();
      wait_out_valid();
      repeat (10) tick();
      chk("held_out_valid", int'(out_valid), 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("accept_after_take", (acc_q.size() > n0) ? acc_q[n0] - hs_cyc : -1, 1);
      wait_out_valid();
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      wait_pops(target);

      // Back-to-back: in_valid and out_ready both held high.
      for (int i = 0; i < 3; i++) begin
         e = '{exp_liv: 1'b1, exp_lst: 1'b0, exp_valid_c: 67};
         sb.push_back(e);
      end
      target = pops + 3;
      n0 = acc_q.size();
      tick();
      in_valid = 1'b1; in_first = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 400 && acc_q.size() < n0 + 3; i++) tick();
      in_valid = 1'b0;
      chk("b2b_accepts", acc_q.size() - n0, 3);
      wait_pops(target);
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++)
         chk("b2b_period", (acc_q.size() >= n0 + 3) ? acc_q[n0+i+1] - acc_q[n0+i] : -1, 68);

      tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
